// File: rtl/result_drain_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : result_drain_ctrl
// Brief    : Drains FP16 results from the result buffer read port and packs
//            PACK results per wide output word for the host write path.
//            Pads and masks the final partial word and pulses done at the end.
// Revision : 1.0 - initial release
// ============================================================================
module result_drain_ctrl #(
  parameter int PACK  = 16,
  parameter int CNT_W = 15
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_start,
  input  logic [CNT_W-1:0]     i_num_results,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_buf_rd_en,
  input  logic [15:0]          i_buf_rd_data,
  input  logic [CNT_W-1:0]     i_buf_count,
  output logic [16*PACK-1:0]   o_out_data,
  output logic [PACK-1:0]      o_out_keep,
  output logic                 o_out_last,
  output logic                 o_out_valid,
  input  logic                 i_out_ready,
  output logic [CNT_W-1:0]     o_drained
);

  // Lane counters must be able to hold the value PACK itself.
  localparam int c_WT_W = $clog2(PACK) + 1;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_RUN       = 2'd1,
    S_WAIT_LAST = 2'd2,
    S_DONE      = 2'd3
  } state_t;

  state_t              r_state;
  logic [CNT_W-1:0]    r_rem;       // results not yet moved to the output register
  logic [c_WT_W-1:0]   r_wt;        // lanes targeted by the word being built
  logic [c_WT_W-1:0]   r_ic;        // lanes whose read has been issued
  logic [c_WT_W-1:0]   r_fc;        // lanes whose data has been captured
  logic                r_pend;      // pack register full, waiting for the output slot
  logic                r_cap;       // a read was issued last cycle; data arrives now
  logic [16*PACK-1:0]  r_pack;

  logic                r_busy;
  logic                r_done;
  logic [16*PACK-1:0]  r_out_data;
  logic [PACK-1:0]     r_out_keep;
  logic                r_out_last;
  logic                r_out_valid;
  logic [CNT_W-1:0]    r_drained;

  logic                w_rd_en;
  logic                w_xfer;
  logic                w_load;
  logic                w_load_last;
  logic [CNT_W-1:0]    w_rem_after;
  logic [PACK-1:0]     w_keep_new;
  logic [CNT_W-1:0]    w_keep_cnt;
  logic [c_WT_W-1:0]   w_fc_inc;

  // Lanes in the next word: a full word, or whatever is left of the job.
  function automatic logic [c_WT_W-1:0] f_word_target(input logic [CNT_W-1:0] n);
    if (n >= CNT_W'(PACK)) begin
      return c_WT_W'(PACK);
    end
    return n[c_WT_W-1:0];
  endfunction

  // Read strobe: only while building a word, with lanes left to issue,
  // data present in the buffer and the pack register not awaiting transfer.
  always_comb begin
    w_rd_en = (r_state == S_RUN) && (r_ic < r_wt) &&
              (i_buf_count != '0) && !r_pend;
  end

  // Handshake, pack-to-output transfer condition and next-word bookkeeping.
  always_comb begin
    w_xfer      = r_out_valid && i_out_ready;
    w_load      = r_pend && (!r_out_valid || i_out_ready);
    w_load_last = (r_rem == CNT_W'(r_wt));
    w_rem_after = r_rem - CNT_W'(r_wt);
    w_fc_inc    = r_fc + c_WT_W'(1);
  end

  // Lane-valid mask for the word currently in the pack register.
  always_comb begin
    w_keep_new = '0;
    for (int k = 0; k < PACK; k++) begin
      w_keep_new[k] = (c_WT_W'(k) < r_wt);
    end
  end

  // Number of valid lanes in the word currently presented downstream.
  always_comb begin
    w_keep_cnt = '0;
    for (int k = 0; k < PACK; k++) begin
      w_keep_cnt = w_keep_cnt + CNT_W'(r_out_keep[k]);
    end
  end

  // Sequencer: job control, read issue, capture into the pack register,
  // transfer to the output register and downstream handshake accounting.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= S_IDLE;
      r_rem       <= '0;
      r_wt        <= '0;
      r_ic        <= '0;
      r_fc        <= '0;
      r_pend      <= 1'b0;
      r_cap       <= 1'b0;
      r_pack      <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_out_data  <= '0;
      r_out_keep  <= '0;
      r_out_last  <= 1'b0;
      r_out_valid <= 1'b0;
      r_drained   <= '0;
    end else begin
      r_done <= 1'b0;

      // Downstream accepted the presented word; a reload below overrides
      // the valid clear so back-to-back words do not bubble.
      if (w_xfer) begin
        r_drained   <= r_drained + w_keep_cnt;
        r_out_valid <= 1'b0;
      end

      if (w_rd_en) begin
        r_ic <= r_ic + c_WT_W'(1);
      end
      r_cap <= w_rd_en;

      // Read data lands one cycle after its strobe, oldest in lane 0.
      if (r_cap) begin
        for (int k = 0; k < PACK; k++) begin
          if (r_fc == c_WT_W'(k)) begin
            r_pack[16*k +: 16] <= i_buf_rd_data;
          end
        end
        r_fc <= w_fc_inc;
        if (w_fc_inc == r_wt) begin
          r_pend <= 1'b1;
        end
      end

      // Move the completed word out and start on the next one.
      if (w_load) begin
        r_out_data  <= r_pack;
        r_out_keep  <= w_keep_new;
        r_out_last  <= w_load_last;
        r_out_valid <= 1'b1;
        r_rem       <= w_rem_after;
        r_wt        <= f_word_target(w_rem_after);
        r_ic        <= '0;
        r_fc        <= '0;
        r_pend      <= 1'b0;
        r_pack      <= '0;
        if (w_load_last) begin
          r_state <= S_WAIT_LAST;
        end
      end

      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_rem     <= i_num_results;
            r_wt      <= f_word_target(i_num_results);
            r_ic      <= '0;
            r_fc      <= '0;
            r_pend    <= 1'b0;
            r_pack    <= '0;
            r_drained <= '0;
            r_busy    <= 1'b1;
            if (i_num_results == '0) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_RUN;
            end
          end
        end
        S_RUN: begin
          // Progress is driven by the read/capture/transfer logic above.
        end
        S_WAIT_LAST: begin
          if (w_xfer && r_out_last) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_buf_rd_en = w_rd_en;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_out_data  = r_out_data;
  assign o_out_keep  = r_out_keep;
  assign o_out_last  = r_out_last;
  assign o_out_valid = r_out_valid;
  assign o_drained   = r_drained;

endmodule
`default_nettype wire

// File: tb/tb_result_drain_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_result_drain_ctrl
// Brief    : Self-checking bench for result_drain_ctrl. A queue models the
//            result buffer; expected words are built from the job's values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_result_drain_ctrl;

  localparam int PACK  = 16;
  localparam int CNT_W = 15;

  logic                clk = 1'b0;
  logic                i_reset;
  logic                i_start;
  logic [CNT_W-1:0]    i_num_results;
  logic                o_busy;
  logic                o_done;
  logic                o_buf_rd_en;
  logic [15:0]         i_buf_rd_data;
  logic [CNT_W-1:0]    i_buf_count;
  logic [16*PACK-1:0]  o_out_data;
  logic [PACK-1:0]     o_out_keep;
  logic                o_out_last;
  logic                o_out_valid;
  logic                i_out_ready;
  logic [CNT_W-1:0]    o_drained;

  always #5 clk = ~clk;

  result_drain_ctrl #(.PACK(PACK), .CNT_W(CNT_W)) u_dut (
    .i_clk         (clk),
    .i_reset       (i_reset),
    .i_start       (i_start),
    .i_num_results (i_num_results),
    .o_busy        (o_busy),
    .o_done        (o_done),
    .o_buf_rd_en   (o_buf_rd_en),
    .i_buf_rd_data (i_buf_rd_data),
    .i_buf_count   (i_buf_count),
    .o_out_data    (o_out_data),
    .o_out_keep    (o_out_keep),
    .o_out_last    (o_out_last),
    .o_out_valid   (o_out_valid),
    .i_out_ready   (i_out_ready),
    .o_drained     (o_drained)
  );

  typedef struct packed {
    logic [16*PACK-1:0] d;
    logic [PACK-1:0]    k;
    logic               l;
  } word_t;

  word_t        exp_q[$];
  logic [15:0]  buf_q[$];
  logic [15:0]  src_q[$];

  int n_cmp = 0;
  int n_err = 0;
  int reads, words, done_cnt, cyc;
  bit job_done, seen_valid, stall_prev;
  int period, tr_cnt, rmode, hold_left, stray_at, bp_exp;
  logic s_done, s_busy;
  logic [16*PACK-1:0] d_prev;
  logic [PACK-1:0]    k_prev;
  logic               l_prev;

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: observe at the falling edge, drive just after the rising edge.
  task automatic cycle();
    bit    pop_now;
    word_t w;
    @(negedge clk);
    s_done  = o_done;
    s_busy  = o_busy;
    pop_now = o_buf_rd_en;
    if (o_buf_rd_en) begin
      reads++;
      check_eq("rd_nonempty", 256'(i_buf_count != '0), 256'(1));
    end
    if (stall_prev) begin
      check_eq("stall_data", o_out_data, d_prev);
      check_eq("stall_keep", 256'(o_out_keep), 256'(k_prev));
      check_eq("stall_last", 256'(o_out_last), 256'(l_prev));
    end
    if (o_out_valid && i_out_ready) begin
      words++;
      if (exp_q.size() == 0) begin
        check_eq("extra_word", 256'(1), 256'(0));
      end else begin
        w = exp_q.pop_front();
        check_eq("word_data", o_out_data, w.d);
        check_eq("word_keep", 256'(o_out_keep), 256'(w.k));
        check_eq("word_last", 256'(o_out_last), 256'(w.l));
      end
    end
    stall_prev = o_out_valid && !i_out_ready;
    d_prev = o_out_data;
    k_prev = o_out_keep;
    l_prev = o_out_last;
    if (o_done) begin
      done_cnt++;
      job_done = 1'b1;
      check_eq("busy_at_done", 256'(o_busy), 256'(1));
    end
    @(posedge clk);
    #1;
    cyc++;
    i_start = 1'b0;
    if (pop_now && buf_q.size() > 0) i_buf_rd_data = buf_q.pop_front();
    if (src_q.size() > 0) begin
      if (tr_cnt == 0) buf_q.push_back(src_q.pop_front());
      tr_cnt = (tr_cnt + 1) % period;
    end
    if (stray_at != 0 && cyc == stray_at) begin
      i_start       = 1'b1;
      i_num_results = CNT_W'(7);
    end
    if (o_out_valid) seen_valid = 1'b1;
    case (rmode)
      1: i_out_ready = ($urandom % 4) != 0;
      2: begin
        if (!seen_valid) begin
          i_out_ready = 1'b0;
        end else if (hold_left > 0) begin
          i_out_ready = 1'b0;
          hold_left--;
          if (hold_left == 0) check_eq("bp_reads", 256'(reads), 256'(bp_exp));
        end else begin
          i_out_ready = 1'b1;
        end
      end
      default: i_out_ready = 1'b1;
    endcase
    i_buf_count = CNT_W'(buf_q.size());
  endtask

  // n results; pat selects 0x3C00+i values; per=0 preloads, else one write per 'per' cycles.
  task automatic run_job(input int n, input bit pat, input int per, input int rm,
                         input int hold, input int stray, input int bpx);
    logic [15:0] vals[$];
    word_t       w;
    for (int i = 0; i < n; i++) vals.push_back(pat ? 16'(16'h3C00 + i) : 16'($urandom));
    for (int s = 0; s < n; s += PACK) begin
      w = '0;
      for (int j = 0; j < PACK && s + j < n; j++) begin
        w.d[16*j +: 16] = vals[s+j];
        w.k[j] = 1'b1;
      end
      w.l = (s + PACK >= n);
      exp_q.push_back(w);
    end
    if (per == 0) begin
      foreach (vals[i]) buf_q.push_back(vals[i]);
    end else begin
      foreach (vals[i]) src_q.push_back(vals[i]);
      period = per;
      tr_cnt = 0;
    end
    i_buf_count = CNT_W'(buf_q.size());
    reads = 0; words = 0; done_cnt = 0; cyc = 0; job_done = 1'b0;
    rmode = rm; hold_left = hold; seen_valid = 1'b0; stray_at = stray; bp_exp = bpx;
    i_start = 1'b1;
    i_num_results = CNT_W'(n);
    cycle();
    cycle();
    check_eq("busy_after_start", 256'(s_busy), 256'(1));
    if (n == 0) check_eq("zero_done_next", 256'(s_done), 256'(1));
    while (!job_done && cyc < 30 * n + 300) cycle();
    check_eq("job_timeout", 256'(job_done), 256'(1));
    cycle();
    check_eq("busy_after_done", 256'(s_busy), 256'(0));
    cycle();
    cycle();
    check_eq("read_count", 256'(reads), 256'(n));
    check_eq("word_count", 256'(words), 256'((n + PACK - 1) / PACK));
    check_eq("exp_left", 256'(exp_q.size()), 256'(0));
    check_eq("done_count", 256'(done_cnt), 256'(1));
    check_eq("drained", 256'(o_drained), 256'(n));
    rmode = 0;
    stray_at = 0;
  endtask

  task automatic check_reset_values(input string tag);
    check_eq({tag, "_busy"},  256'(o_busy), 256'(0));
    check_eq({tag, "_done"},  256'(o_done), 256'(0));
    check_eq({tag, "_rden"},  256'(o_buf_rd_en), 256'(0));
    check_eq({tag, "_valid"}, 256'(o_out_valid), 256'(0));
    check_eq({tag, "_last"},  256'(o_out_last), 256'(0));
    check_eq({tag, "_data"},  o_out_data, 256'(0));
    check_eq({tag, "_keep"},  256'(o_out_keep), 256'(0));
    check_eq({tag, "_drained"}, 256'(o_drained), 256'(0));
  endtask

  initial begin
    i_reset = 1'b1; i_start = 1'b0; i_num_results = '0;
    i_buf_rd_data = '0; i_buf_count = '0; i_out_ready = 1'b1;
    rmode = 0; stray_at = 0; period = 1; tr_cnt = 0; stall_prev = 1'b0;
    cycle();
    cycle();
    check_reset_values("reset");
    i_reset = 1'b0;
    cycle();

    run_job(32, 1'b1, 0, 0, 0, 0, 0);   // two full words
    run_job(5,  1'b0, 0, 0, 0, 0, 0);   // partial final word
    run_job(20, 1'b0, 4, 0, 0, 0, 0);   // trickling buffer
    run_job(48, 1'b0, 0, 2, 30, 0, 32); // backpressure: one word held, one word packed
    run_job(0,  1'b0, 0, 0, 0, 0, 0);   // zero-length job
    run_job(24, 1'b0, 0, 0, 0, 5, 0);   // start during busy job is ignored

    // Reset in the middle of a job, then a fresh job.
    exp_q.delete();
    for (int i = 0; i < 40; i++) buf_q.push_back(16'($urandom));
    i_buf_count = CNT_W'(buf_q.size());
    i_start = 1'b1;
    i_num_results = CNT_W'(40);
    for (int i = 0; i < 12; i++) cycle();
    i_reset = 1'b1;
    cycle();
    buf_q.delete(); src_q.delete(); exp_q.delete();
    i_buf_count = '0; i_buf_rd_data = '0; stall_prev = 1'b0;
    #1;
    check_reset_values("midreset");
    i_reset = 1'b0;
    cycle();
    run_job(16, 1'b0, 0, 0, 0, 0, 0);

    for (int t = 0; t < 6; t++) begin
      run_job(int'($urandom_range(1, 70)), 1'b0, int'($urandom_range(0, 3)), 1, 0, 0, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
